// File: rtl/step_dir_gen.sv
// Step/direction pulse scheduler for one axis: executes queued moves with a
// guaranteed step high time, a minimum step period and dir-to-step setup time.
module step_dir_gen #(
    parameter int PW        = 8,
    parameter int DIR_SETUP = 16,
    parameter int CNT_W     = 16,
    parameter int PER_W     = 16
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_n,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    localparam int SETUP_W = $clog2(DIR_SETUP + 1);
    localparam int TMR_W   = (PER_W + 1 > SETUP_W) ? PER_W + 1 : SETUP_W;

    localparam logic [PER_W:0] PW_EXT  = (PER_W + 1)'(PW);
    localparam logic [PER_W:0] MIN_PER = (PER_W + 1)'(2 * PW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIR_SET,
        ST_PULSE_HI,
        ST_PULSE_LO
    } state_t;

    state_t             state_reg, state_next;
    logic               hold_valid_reg, hold_valid_next;
    logic               hold_dir_reg, hold_dir_next;
    logic [CNT_W-1:0]   hold_n_reg, hold_n_next;
    logic [PER_W-1:0]   hold_period_reg, hold_period_next;
    logic               dir_reg, dir_next;
    logic               step_reg, step_next;
    logic               done_reg, done_next;
    logic               aborted_reg, aborted_next;
    logic               abort_pend_reg, abort_pend_next;
    logic [CNT_W-1:0]   steps_left_reg, steps_left_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [PER_W:0]     low_time_reg, low_time_next;

    logic               accept;
    logic               abort_req;
    logic               timer_last;
    logic [PER_W:0]     per_ext;
    logic [PER_W:0]     p_eff;
    logic [PER_W:0]     low_time_calc;

    // Period is widened by one bit so the 2*PW floor never overflows.
    assign per_ext       = {1'b0, hold_period_reg};
    assign p_eff         = (per_ext > MIN_PER) ? per_ext : MIN_PER;
    assign low_time_calc = p_eff - PW_EXT;

    assign cmd_ready  = !hold_valid_reg && !abort;
    assign accept     = cmd_valid && cmd_ready;
    assign abort_req  = abort || abort_pend_reg;
    assign timer_last = (timer_reg == TMR_W'(1));

    always_comb begin
        state_next       = state_reg;
        hold_valid_next  = hold_valid_reg;
        hold_dir_next    = hold_dir_reg;
        hold_n_next      = hold_n_reg;
        hold_period_next = hold_period_reg;
        dir_next         = dir_reg;
        step_next        = step_reg;
        done_next        = 1'b0;
        aborted_next     = 1'b0;
        abort_pend_next  = abort_req;
        steps_left_next  = steps_left_reg;
        timer_next       = timer_reg;
        low_time_next    = low_time_reg;

        if (accept) begin
            hold_valid_next  = 1'b1;
            hold_dir_next    = cmd_dir;
            hold_n_next      = cmd_n;
            hold_period_next = cmd_period;
        end

        case (state_reg)
            ST_IDLE: begin
                if (abort_req) begin
                    state_next      = ST_IDLE;
                    step_next       = 1'b0;
                    steps_left_next = '0;
                    hold_valid_next = 1'b0;
                    aborted_next    = 1'b1;
                    abort_pend_next = 1'b0;
                end else if (hold_valid_reg) begin
                    hold_valid_next = 1'b0;
                    steps_left_next = hold_n_reg;
                    low_time_next   = low_time_calc;
                    if (hold_n_reg == '0) begin
                        done_next = 1'b1;
                    end else if (hold_dir_reg != dir_reg) begin
                        dir_next   = hold_dir_reg;
                        timer_next = TMR_W'(DIR_SETUP);
                        state_next = ST_DIR_SET;
                    end else begin
                        step_next  = 1'b1;
                        timer_next = TMR_W'(PW);
                        state_next = ST_PULSE_HI;
                    end
                end
            end

            ST_DIR_SET: begin
                if (abort_req) begin
                    state_next      = ST_IDLE;
                    step_next       = 1'b0;
                    steps_left_next = '0;
                    hold_valid_next = 1'b0;
                    aborted_next    = 1'b1;
                    abort_pend_next = 1'b0;
                end else if (timer_last) begin
                    step_next  = 1'b1;
                    timer_next = TMR_W'(PW);
                    state_next = ST_PULSE_HI;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end

            ST_PULSE_HI: begin
                // A pending abort waits here so the pulse keeps its full width.
                if (timer_last) begin
                    step_next = 1'b0;
                    if (steps_left_reg != '0) begin
                        steps_left_next = steps_left_reg - CNT_W'(1);
                    end
                    if (abort_req) begin
                        state_next      = ST_IDLE;
                        steps_left_next = '0;
                        hold_valid_next = 1'b0;
                        aborted_next    = 1'b1;
                        abort_pend_next = 1'b0;
                    end else begin
                        timer_next = TMR_W'(low_time_reg);
                        state_next = ST_PULSE_LO;
                    end
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end

            ST_PULSE_LO: begin
                if (abort_req) begin
                    state_next      = ST_IDLE;
                    step_next       = 1'b0;
                    steps_left_next = '0;
                    hold_valid_next = 1'b0;
                    aborted_next    = 1'b1;
                    abort_pend_next = 1'b0;
                end else if (timer_last) begin
                    if (steps_left_reg != '0) begin
                        step_next  = 1'b1;
                        timer_next = TMR_W'(PW);
                        state_next = ST_PULSE_HI;
                    end else begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                step_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_reg       <= ST_IDLE;
            hold_valid_reg  <= 1'b0;
            hold_dir_reg    <= 1'b0;
            hold_n_reg      <= '0;
            hold_period_reg <= '0;
            dir_reg         <= 1'b0;
            step_reg        <= 1'b0;
            done_reg        <= 1'b0;
            aborted_reg     <= 1'b0;
            abort_pend_reg  <= 1'b0;
            steps_left_reg  <= '0;
            timer_reg       <= '0;
            low_time_reg    <= '0;
        end else if (sclr) begin
            state_reg       <= ST_IDLE;
            hold_valid_reg  <= 1'b0;
            hold_dir_reg    <= 1'b0;
            hold_n_reg      <= '0;
            hold_period_reg <= '0;
            dir_reg         <= 1'b0;
            step_reg        <= 1'b0;
            done_reg        <= 1'b0;
            aborted_reg     <= 1'b0;
            abort_pend_reg  <= 1'b0;
            steps_left_reg  <= '0;
            timer_reg       <= '0;
            low_time_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            hold_valid_reg  <= hold_valid_next;
            hold_dir_reg    <= hold_dir_next;
            hold_n_reg      <= hold_n_next;
            hold_period_reg <= hold_period_next;
            dir_reg         <= dir_next;
            step_reg        <= step_next;
            done_reg        <= done_next;
            aborted_reg     <= aborted_next;
            abort_pend_reg  <= abort_pend_next;
            steps_left_reg  <= steps_left_next;
            timer_reg       <= timer_next;
            low_time_reg    <= low_time_next;
        end
    end

    assign step       = step_reg;
    assign dir        = dir_reg;
    assign done       = done_reg;
    assign aborted    = aborted_reg;
    assign steps_left = steps_left_reg;
    assign busy       = (state_reg != ST_IDLE) || hold_valid_reg;

endmodule

// File: tb/tb_step_dir_gen.sv
// Bench for step_dir_gen: tasks queue expected step/done/aborted events and a
// negedge monitor pops and compares them as the DUT produces them.
module tb_step_dir_gen;

    localparam int PW        = 8;
    localparam int DIR_SETUP = 16;
    localparam int CNT_W     = 16;
    localparam int PER_W     = 16;

    // kind: 0 = step pulse, 1 = done, 2 = aborted
    // mode: 0 = check val against rise gap / low time, 1 = against dir setup, 2 = no timing check
    typedef struct {
        int   kind;
        int   width;
        int   mode;
        int   val;
        logic d;
        int   sl_rise;
        int   sl_fall;
    } ev_t;

    logic             clk = 1'b0;
    logic             aclr = 1'b1;
    logic             sclr = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_n = '0;
    logic [PER_W-1:0] cmd_period = '0;
    logic             abort = 1'b0;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] steps_left;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    logic model_dir = 1'b0;
    logic mon_en = 1'b1;
    int   done_cnt = 0;

    logic step_prev = 1'b0;
    logic dir_prev = 1'b0;
    int   dir_chg_cyc = 0;
    int   rise_cyc = 0;
    int   rise_gap = 0;
    int   rise_setup = 0;
    int   rise_sl = 0;
    int   fall_cyc = 0;

    step_dir_gen #(
        .PW(PW), .DIR_SETUP(DIR_SETUP), .CNT_W(CNT_W), .PER_W(PER_W)
    ) dut (
        .clk(clk), .aclr(aclr), .sclr(sclr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_n(cmd_n), .cmd_period(cmd_period), .abort(abort),
        .step(step), .dir(dir), .busy(busy), .done(done), .aborted(aborted),
        .steps_left(steps_left)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (dir !== dir_prev) dir_chg_cyc = cyc;
        if (step && !step_prev) begin
            rise_gap   = cyc - rise_cyc;
            rise_setup = cyc - dir_chg_cyc;
            rise_cyc   = cyc;
            rise_sl    = int'(steps_left);
        end
        if (mon_en && !step && step_prev) begin
            $display("pulse width=%0d gap=%0d setup=%0d dir=%0b left=%0d->%0d",
                     cyc - rise_cyc, rise_gap, rise_setup, dir, rise_sl, steps_left);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got pulse expected no event");
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== 0) begin
                    errors++;
                    $display("FAIL event_kind got pulse expected kind %0d", e.kind);
                end else begin
                    checks++;
                    if (cyc - rise_cyc !== e.width) begin
                        errors++;
                        $display("FAIL pulse_width got %0d expected %0d", cyc - rise_cyc, e.width);
                    end
                    checks++;
                    if (dir !== e.d) begin
                        errors++;
                        $display("FAIL pulse_dir got %0b expected %0b", dir, e.d);
                    end
                    checks++;
                    if (rise_sl !== e.sl_rise) begin
                        errors++;
                        $display("FAIL steps_left_hi got %0d expected %0d", rise_sl, e.sl_rise);
                    end
                    checks++;
                    if (int'(steps_left) !== e.sl_fall) begin
                        errors++;
                        $display("FAIL steps_left_lo got %0d expected %0d", steps_left, e.sl_fall);
                    end
                    if (e.mode == 0) begin
                        checks++;
                        if (rise_gap !== e.val) begin
                            errors++;
                            $display("FAIL rise_period got %0d expected %0d", rise_gap, e.val);
                        end
                    end else if (e.mode == 1) begin
                        checks++;
                        if (rise_setup !== e.val) begin
                            errors++;
                            $display("FAIL dir_setup got %0d expected %0d", rise_setup, e.val);
                        end
                    end
                end
            end
        end
        if (!step && step_prev) fall_cyc = cyc;
        if (done) begin
            done_cnt++;
            if (mon_en) begin
                $display("done low=%0d dir=%0b", cyc - fall_cyc, dir);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got done expected no event");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== 1) begin
                        errors++;
                        $display("FAIL event_kind got done expected kind %0d", e.kind);
                    end else if (e.mode == 0) begin
                        checks++;
                        if (cyc - fall_cyc !== e.val) begin
                            errors++;
                            $display("FAIL done_low_time got %0d expected %0d", cyc - fall_cyc, e.val);
                        end
                    end
                end
            end
        end
        if (aborted && mon_en) begin
            $display("aborted dir=%0b", dir);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_aborted got aborted expected no event");
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== 2) begin
                    errors++;
                    $display("FAIL event_kind got aborted expected kind %0d", e.kind);
                end
            end
        end
        step_prev = step;
        dir_prev  = dir;
    end

    // Reference model of one command: PW-wide pulses P apart, then done.
    task automatic push_cmd(input logic d, input int n, input int per);
        ev_t e;
        int  p;
        p = (per > 2 * PW) ? per : 2 * PW;
        for (int i = 0; i < n; i++) begin
            e.kind = 0; e.width = PW; e.d = d;
            e.sl_rise = n - i; e.sl_fall = n - 1 - i;
            if (i > 0) begin
                e.mode = 0; e.val = p;
            end else if (d != model_dir) begin
                e.mode = 1; e.val = DIR_SETUP;
            end else begin
                e.mode = 2; e.val = 0;
            end
            exp_q.push_back(e);
        end
        e.kind = 1; e.width = 0; e.d = d; e.sl_rise = 0; e.sl_fall = 0;
        e.mode = (n > 0) ? 0 : 2;
        e.val  = p - PW;
        exp_q.push_back(e);
        if (n > 0) model_dir = d;
    endtask

    task automatic push_event(input int kind, input int sl_rise, input int sl_fall);
        ev_t e;
        e.kind = kind; e.width = PW; e.mode = 2; e.val = 0; e.d = model_dir;
        e.sl_rise = sl_rise; e.sl_fall = sl_fall;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic d, input int n, input int per);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = d; cmd_n = CNT_W'(n); cmd_period = PER_W'(per);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept_timeout got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({step, dir, busy, done, aborted} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00000", {step, dir, busy, done, aborted});
        end
        checks++;
        if (steps_left !== '0) begin
            errors++;
            $display("FAIL reset_steps_left got %0d expected 0", steps_left);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        push_cmd(1'b0, 3, 20);
        send_cmd(1'b0, 3, 20);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b expected 1", busy);
        end
        wait_drain();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_busy got %b expected 0", busy);
        end
    endtask

    task automatic test_dir_change();
        push_cmd(1'b1, 1, 20);
        send_cmd(1'b1, 1, 20);
        wait_drain();
        checks++;
        if (dir !== 1'b1) begin
            errors++;
            $display("FAIL dir_change_level got %b expected 1", dir);
        end
    endtask

    task automatic test_clamp();
        push_cmd(1'b1, 2, 5);
        send_cmd(1'b1, 2, 5);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int dc0;
        push_cmd(1'b1, 2, 20);
        push_cmd(1'b1, 1, 20);
        push_cmd(1'b1, 1, 20);
        dc0 = done_cnt;
        send_cmd(1'b1, 2, 20);
        send_cmd(1'b1, 1, 20);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold_full_ready got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_n = CNT_W'(1); cmd_period = PER_W'(20);
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt - dc0 !== 1) begin
            errors++;
            $display("FAIL b2b_third_accept got %0d done pulses before accept expected 1", done_cnt - dc0);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_abort();
        int t = 0;
        push_event(0, 5, 0);
        push_event(2, 0, 0);
        send_cmd(1'b1, 5, 20);
        while (!step && t < 100) begin
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_n = CNT_W'(2); cmd_period = PER_W'(20);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_queue_ready got %b expected 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse_held got %b expected 1", step);
        end
        wait_drain();
        checks++;
        if ({busy, cmd_ready, dir} !== 3'b011) begin
            errors++;
            $display("FAIL abort_flushed got busy,ready,dir=%b expected 011", {busy, cmd_ready, dir});
        end
        checks++;
        if (steps_left !== '0) begin
            errors++;
            $display("FAIL abort_steps_left got %0d expected 0", steps_left);
        end
        push_event(2, 0, 0);
        @(negedge clk);
        abort = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_blocks_ready got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        abort = 1'b0;
        wait_drain();
    endtask

    task automatic test_zero();
        push_cmd(1'b0, 0, 20);
        send_cmd(1'b0, 0, 20);
        wait_drain();
        checks++;
        if (dir !== model_dir) begin
            errors++;
            $display("FAIL zero_dir_unchanged got %b expected %b", dir, model_dir);
        end
    endtask

    task automatic test_aclr();
        int t = 0;
        int stray = 0;
        mon_en = 1'b0;
        send_cmd(1'b1, 4, 20);
        while (!step && t < 100) begin
            @(negedge clk);
            t++;
        end
        #2 aclr = 1'b1;
        #1;
        checks++;
        if ({step, dir, busy} !== 3'b000) begin
            errors++;
            $display("FAIL aclr_immediate got step,dir,busy=%b expected 000", {step, dir, busy});
        end
        @(negedge clk);
        aclr = 1'b0;
        model_dir = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || aborted || step) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL aclr_quiet got %0d active cycles expected 0", stray);
        end
        checks++;
        if (cmd_ready !== 1'b1 || steps_left !== '0) begin
            errors++;
            $display("FAIL aclr_release got ready=%b left=%0d expected ready=1 left=0", cmd_ready, steps_left);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_sclr();
        int t = 0;
        int stray = 0;
        mon_en = 1'b0;
        send_cmd(1'b1, 2, 20);
        while (!dir && t < 100) begin
            @(negedge clk);
            t++;
        end
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        checks++;
        if ({step, dir, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL sclr_state got step,dir,busy,ready=%b expected 0001", {step, dir, busy, cmd_ready});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || aborted || step) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL sclr_quiet got %0d active cycles expected 0", stray);
        end
        model_dir = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_recover();
        push_cmd(1'b0, 2, 24);
        send_cmd(1'b0, 2, 24);
        wait_drain();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        aclr = 1'b0;
        test_reset();
        test_basic();
        test_dir_change();
        test_clamp();
        test_back_to_back();
        test_abort();
        test_zero();
        test_aclr();
        test_sclr();
        test_recover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
